// File: rtl/sample_mem_responder.sv
// sample_mem_responder: on-chip stand-in for the SDRAM controller behind the audio sample store.
// Latency: busy rises 1 cycle after a request is seen in IDLE; read_ready pulses ACCESS_CYCLES+1 cycles after busy rises.
// Backpressure: while busy is high the initiator keeps its request level held; refresh stalls delay acceptance.
// Ports: clk100 / rst (async, active-low); read+raddr, write+waddr+wdata requests;
//        rdata + read_ready (one-cycle pulse), busy handshake, state (debug view of the FSM).
module sample_mem_responder #(
  parameter int unsigned ADDR_W         = 25,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned MEM_AW         = 12,
  parameter int unsigned ACCESS_CYCLES  = 4,
  parameter int unsigned REFRESH_PERIOD = 780,
  parameter int unsigned REFRESH_CYCLES = 8
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              read_ready,
  output logic [2:0]        state
);

  localparam int unsigned DEPTH   = 1 << MEM_AW;
  localparam int unsigned RT_W    = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int unsigned RP_LAST = (REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ACC  = 3'd1,
    S_RD_ACC  = 3'd2,
    S_HOLD    = 3'd3,
    S_REFRESH = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic                hold_wr_q, hold_wr_d;
  logic                hold_rd_q, hold_rd_d;
  logic                rd_fire_q, rd_fire_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                read_ready_q, read_ready_d;
  logic [RT_W-1:0]     rtimer_q, rtimer_d;
  logic                rpend_q, rpend_d;
  logic                mem_we;
  logic                rwrap;
  logic                rtake;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Channel bit (address MSB) is kept as the top index bit so left/right
  // sample streams never alias; the remaining upper bits are don't-care.
  function automatic logic [MEM_AW-1:0] mem_idx(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1], a[MEM_AW-2:0]};
  endfunction

  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr[ADDR_W-2:MEM_AW-1], waddr[ADDR_W-2:MEM_AW-1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    hold_wr_d = hold_wr_q;
    hold_rd_d = hold_rd_q;
    rd_fire_d = 1'b0;
    mem_we    = 1'b0;
    rtake     = 1'b0;

    // Refresh timer free-runs in every state; a wrap while a refresh is
    // already pending is simply absorbed.
    rwrap    = (REFRESH_PERIOD != 0) && (rtimer_q == RT_W'(RP_LAST));
    rtimer_d = ((REFRESH_PERIOD == 0) || rwrap) ? '0 : rtimer_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (rpend_q) begin
          rtake     = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = 8'(REFRESH_CYCLES - 1);
          hold_wr_d = 1'b0;
          hold_rd_d = 1'b0;
          state_d   = S_REFRESH;
        end else if (write) begin
          addr_d    = mem_idx(waddr);
          wdat_d    = wdata;
          busy_d    = 1'b1;
          cnt_d     = 8'(ACCESS_CYCLES - 1);
          hold_wr_d = 1'b1;
          hold_rd_d = 1'b0;
          state_d   = S_WR_ACC;
        end else if (read) begin
          addr_d    = mem_idx(raddr);
          busy_d    = 1'b1;
          cnt_d     = 8'(ACCESS_CYCLES - 1);
          hold_wr_d = 1'b0;
          hold_rd_d = 1'b1;
          state_d   = S_RD_ACC;
        end
      end
      S_WR_ACC: begin
        if (cnt_q == 8'd0) begin
          mem_we  = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RD_ACC: begin
        // The array read is taken one cycle later, so read_ready lands
        // ACCESS_CYCLES+1 cycles after busy rose.
        if (cnt_q == 8'd0) begin
          rd_fire_d = 1'b1;
          state_d   = S_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_REFRESH: begin
        if (cnt_q == 8'd0) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        // Only the level that was just served keeps busy high. A different
        // request held meanwhile (read behind a write, or anything behind a
        // refresh) must not block the return to IDLE, or it would never be
        // served.
        if (!(hold_wr_q && write) && !(hold_rd_q && read)) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    rpend_d      = rpend_q ? !rtake : rwrap;
    read_ready_d = rd_fire_q;
    rdata_d      = rd_fire_q ? mem[addr_q] : rdata_q;
  end

  always_ff @(posedge clk100 or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      busy_q       <= 1'b0;
      addr_q       <= '0;
      wdat_q       <= '0;
      hold_wr_q    <= 1'b0;
      hold_rd_q    <= 1'b0;
      rd_fire_q    <= 1'b0;
      rdata_q      <= '0;
      read_ready_q <= 1'b0;
      rtimer_q     <= '0;
      rpend_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      addr_q       <= addr_d;
      wdat_q       <= wdat_d;
      hold_wr_q    <= hold_wr_d;
      hold_rd_q    <= hold_rd_d;
      rd_fire_q    <= rd_fire_d;
      rdata_q      <= rdata_d;
      read_ready_q <= read_ready_d;
      rtimer_q     <= rtimer_d;
      rpend_q      <= rpend_d;
    end
  end

  // Array contents survive reset; the commit strobe comes from reset state,
  // so an aborted write never lands.
  always_ff @(posedge clk100) begin
    if (mem_we) begin
      mem[addr_q] <= wdat_q;
    end
  end

  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign read_ready = read_ready_q;
  assign state      = state_q;

endmodule

// File: tb/tb_sample_mem_responder.sv
module tb_sample_mem_responder;
  localparam int AC = 4;
  localparam int RP = 20;
  localparam int RC = 8;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_REF  = 3'd4;

  logic        clk100 = 1'b0;
  logic        rst    = 1'b0;
  logic        read   = 1'b0;
  logic        write  = 1'b0;
  logic [24:0] raddr  = '0;
  logic [24:0] waddr  = '0;
  logic [15:0] wdata  = '0;
  logic [15:0] rdata;
  logic        busy;
  logic        read_ready;
  logic [2:0]  state;

  sample_mem_responder #(
    .ADDR_W(25), .DATA_W(16), .MEM_AW(12),
    .ACCESS_CYCLES(AC), .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)
  ) dut (
    .clk100(clk100), .rst(rst), .read(read), .write(write),
    .raddr(raddr), .waddr(waddr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .read_ready(read_ready), .state(state)
  );

  always #5 clk100 = ~clk100;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int ec = 0;          // rising edges since reset release
  int rd_acc_cyc = 0;

  logic [15:0] mem_m [4096];
  bit          written_m [4096];
  int          wlist [$];
  logic [15:0] exp_q [$];

  always @(posedge clk100) begin
    cyc <= cyc + 1;
    if (!rst) ec <= 0;
    else      ec <= ec + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int idx(input logic [24:0] a);
    return int'({a[24], a[10:0]});
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void model_wr(input logic [24:0] a, input logic [15:0] d);
    int i;
    i = idx(a);
    mem_m[i] = d;
    if (!written_m[i]) wlist.push_back(i);
    written_m[i] = 1'b1;
  endfunction

  // Scoreboard monitor: every read_ready pulse consumes one expectation.
  always @(negedge clk100) begin
    if (rst === 1'b1 && read_ready === 1'b1) begin
      chk("rd_outstanding", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        chk("rd_data", rdata, exp_q.pop_front());
        chk("rd_latency", cyc - rd_acc_cyc, AC + 1);
      end
    end
  end

  task automatic wait_state(input string nm, input logic [2:0] s);
    int i;
    i = 0;
    do begin
      @(negedge clk100);
      i++;
    end while (state !== s && i < 300);
    chk(nm, state, s);
  endtask

  // Called on the acceptance cycle: holds the request 'hold' cycles, then
  // counts how long busy stays high.
  task automatic count_busy(input string nm, input int hold, input bit is_wr);
    int n;
    int i;
    n = 0;
    i = 0;
    while (i < 300) begin
      if (i == hold) begin
        if (is_wr) write = 1'b0;
        else       read  = 1'b0;
      end
      if (busy !== 1'b1) break;
      n++;
      i++;
      @(negedge clk100);
    end
    write = 1'b0;
    read  = 1'b0;
    chk(nm, n, imax(AC + 1, hold + 1));
  endtask

  task automatic do_write(input logic [24:0] a, input logic [15:0] d, input int hold);
    @(negedge clk100);
    write = 1'b1; waddr = a; wdata = d;
    wait_state("wr_accept", S_WR);
    model_wr(a, d);
    count_busy("wr_busy", hold, 1'b1);
  endtask

  task automatic do_read(input logic [24:0] a, input int hold);
    @(negedge clk100);
    read = 1'b1; raddr = a;
    wait_state("rd_accept", S_RD);
    exp_q.push_back(mem_m[idx(a)]);
    rd_acc_cyc = cyc;
    count_busy("rd_busy", hold, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int i;
    int lo;
    int k;
    int hold;
    logic [24:0] a;
    logic [15:0] d;

    repeat (3) @(negedge clk100);
    chk("rst_busy", busy, 0);
    chk("rst_read_ready", read_ready, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_state", state, S_IDLE);
    rst = 1'b1;

    // Basic write then read-back.
    do_write(25'h0000005, 16'h1234, 0);
    do_read(25'h0000005, 0);

    // Channel bit keeps the two streams apart.
    do_write(25'h1000005, 16'hAAAA, 0);
    do_write(25'h0000005, 16'h5555, 0);
    do_read(25'h1000005, 0);
    do_read(25'h0000005, 0);

    // Non-channel upper bits alias onto the same word.
    do_write(25'h0ABC805, 16'h7777, 0);
    do_read(25'h0000005, 0);

    // Read and write together: write first, held read afterwards.
    @(negedge clk100);
    write = 1'b1; read = 1'b1;
    waddr = 25'h0000007; raddr = 25'h0000007; wdata = 16'h0BEE;
    wait_state("both_wr_first", S_WR);
    model_wr(25'h0000007, 16'h0BEE);
    write = 1'b0;
    wait_state("both_rd_next", S_RD);
    exp_q.push_back(mem_m[idx(25'h0000007)]);
    rd_acc_cyc = cyc;
    read = 1'b0;
    i = 0;
    while (busy === 1'b1 && i < 300) begin @(negedge clk100); i++; end

    // Write level held 10 cycles past busy rise: one access, busy tracks the level.
    do_write(25'h0000009, 16'h4242, 10);
    do_read(25'h0000009, 0);

    // Write raised on the cycle refresh becomes pending: refresh goes first.
    i = 0;
    do begin
      @(negedge clk100);
      i++;
    end while (!(ec > 0 && ec % RP == 0 && state === S_IDLE) && i < 300);
    write = 1'b1; waddr = 25'h0000011; wdata = 16'hC0DE;
    @(negedge clk100);
    chk("refresh_first", state, S_REF);
    n = 0; i = 0;
    while (busy === 1'b1 && i < 300) begin n++; i++; @(negedge clk100); end
    chk("refresh_busy", n, RC + 1);
    wait_state("wr_after_refresh", S_WR);
    model_wr(25'h0000011, 16'hC0DE);
    count_busy("wr_busy", 0, 1'b1);
    do_read(25'h0000011, 0);

    // Reset two cycles into a write access (cnt==1): the write is lost.
    do_write(25'h0000020, 16'h1111, 0);
    @(negedge clk100);
    write = 1'b1; waddr = 25'h0000020; wdata = 16'h2222;
    wait_state("abort_accept", S_WR);
    write = 1'b0;
    repeat (2) @(negedge clk100);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_state", state, S_IDLE);
    chk("abort_rdata", rdata, 0);
    @(negedge clk100);
    rst = 1'b1;
    do_read(25'h0000020, 0);

    // Randomised traffic against the array model.
    for (int t = 0; t < 60; t++) begin
      lo   = $urandom_range(0, 15);
      hold = $urandom_range(0, 3);
      if (wlist.size() == 0 || $urandom_range(0, 1) == 1) begin
        a = {1'($urandom_range(0, 1)), 13'($urandom), 11'(lo)};
        d = 16'($urandom);
        do_write(a, d, hold);
      end else begin
        k = wlist[$urandom_range(0, wlist.size() - 1)];
        a = {k[11], 13'($urandom), k[10:0]};
        do_read(a, hold);
      end
    end

    i = 0;
    while (exp_q.size() > 0 && i < 50) begin @(negedge clk100); i++; end
    chk("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
